// File: rtl/led_breath_pwm_pkg.sv
// ---------------------------------------------------------------------------
// led_breath_pwm_pkg
// Shared definitions for the LED breathing PWM stage: FSM state encoding and
// default sizing values (also used by the blink counter's delay constants).
// Ports: none (package).
// ---------------------------------------------------------------------------
package led_breath_pwm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    localparam int DEF_PWM_BITS   = 8;
    localparam int DEF_STEP_DIV   = 1526;
    localparam int DEF_HOLD_STEPS = 64;

endpackage

// File: rtl/led_pwm_gen.sv
// ---------------------------------------------------------------------------
// led_pwm_gen
// Free-running PWM counter with a registered duty comparator.
// Ports:
//   sys_clk  - clock
//   sys_rst  - synchronous active-high reset
//   duty     - duty value, high for duty of 2^PWM_BITS cycles
//   wrap     - high on the last count of each PWM period
//   led_pwm  - registered PWM output
// ---------------------------------------------------------------------------
module led_pwm_gen
    import led_breath_pwm_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [PWM_BITS-1:0] duty,
    output logic                wrap,
    output logic                led_pwm
);

    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pwm_cnt <= '0;
            led_pwm <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led_pwm <= (pwm_cnt < duty);
        end
    end

    assign wrap = (pwm_cnt == {PWM_BITS{1'b1}});

endmodule

// File: rtl/led_breath_pwm.sv
// ---------------------------------------------------------------------------
// led_breath_pwm
// Turns a slow enable level into a breathing LED: the duty of a fixed-period
// PWM ramps up, holds at the top, ramps down and holds at the bottom.
// Ports:
//   sys_clk  - clock (single domain)
//   sys_rst  - synchronous active-high reset
//   en       - breathing request level, synchronized internally
//   led_pwm  - registered PWM drive to the LED pin
//   duty     - current duty value (debug)
//   busy     - high whenever the FSM is not IDLE
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | duty forced to 0, waiting for en
// RISE    | duty +1 per step until full scale
// HOLD_HI | duty at full scale for HOLD_STEPS steps
// FALL    | duty -1 per step until 0
// HOLD_LO | duty at 0 for HOLD_STEPS steps, then re-rise
// ---------------------------------------------------------------------------
module led_breath_pwm
    import led_breath_pwm_pkg::*;
#(
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter int STEP_DIV   = DEF_STEP_DIV,
    parameter int HOLD_STEPS = DEF_HOLD_STEPS
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                en,
    output logic                led_pwm,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX    = '1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX_M1 = DUTY_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE    = PWM_BITS'(1);
    localparam logic [15:0]         STEP_LAST   = 16'(STEP_DIV - 1);
    localparam logic [15:0]         HOLD_LAST   = 16'(HOLD_STEPS - 1);

    logic        en_meta;
    logic        en_s;
    logic        wrap;
    logic        step;
    logic [15:0] step_cnt;
    logic [15:0] hold_cnt;
    state_t      state;

    led_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .duty    (duty),
        .wrap    (wrap),
        .led_pwm (led_pwm)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            en_meta <= 1'b0;
            en_s    <= 1'b0;
        end else begin
            en_meta <= en;
            en_s    <= en_meta;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            step_cnt <= '0;
        end else if (wrap) begin
            step_cnt <= (step_cnt == STEP_LAST) ? 16'd0 : step_cnt + 1'b1;
        end
    end

    // Steps land on the last PWM count, so a new duty first takes effect at
    // pwm_cnt = 0 of the following period.
    assign step = wrap && (step_cnt == STEP_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            duty     <= '0;
            hold_cnt <= '0;
            busy     <= 1'b0;
        end else if (step) begin
            case (state)
                IDLE: begin
                    duty     <= '0;
                    hold_cnt <= '0;
                    if (en_s) begin
                        state <= RISE;
                        busy  <= 1'b1;
                    end
                end
                RISE: begin
                    // Dropping en wins over the increment on the same step.
                    if (!en_s) begin
                        state <= FALL;
                    end else if (duty == DUTY_MAX) begin
                        state    <= HOLD_HI;
                        hold_cnt <= '0;
                    end else begin
                        duty <= duty + 1'b1;
                        if (duty == DUTY_MAX_M1) begin
                            state    <= HOLD_HI;
                            hold_cnt <= '0;
                        end
                    end
                end
                HOLD_HI: begin
                    if (!en_s || hold_cnt == HOLD_LAST) begin
                        state    <= FALL;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                FALL: begin
                    // An abort right after leaving IDLE enters FALL at 0, so
                    // guard against wrapping below zero.
                    if (duty == '0 || duty == DUTY_ONE) begin
                        duty     <= '0;
                        hold_cnt <= '0;
                        if (en_s) begin
                            state <= HOLD_LO;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        duty <= duty - 1'b1;
                    end
                end
                HOLD_LO: begin
                    if (!en_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= RISE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    duty     <= '0;
                    hold_cnt <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_breath_pwm.sv
// ---------------------------------------------------------------------------
// tb_led_breath_pwm
// Directed bench for led_breath_pwm with PWM_BITS=4, STEP_DIV=2, HOLD_STEPS=3
// (one step = 32 clocks). Expected duty/busy per step are queued by the
// stimulus sequence and popped by a monitor at every step boundary.
// ---------------------------------------------------------------------------
module tb_led_breath_pwm;

    localparam int PWM_BITS   = 4;
    localparam int STEP_DIV   = 2;
    localparam int HOLD_STEPS = 3;
    localparam int PERIOD     = 16;
    localparam int STEP_CYC   = PERIOD * STEP_DIV;

    logic                sys_clk = 1'b0;
    logic                sys_rst = 1'b1;
    logic                en      = 1'b1;
    logic                led_pwm;
    logic [PWM_BITS-1:0] duty;
    logic                busy;

    typedef struct {
        logic [PWM_BITS-1:0] duty;
        logic                busy;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   tcnt   = 0;
    bit   track  = 1'b0;

    led_breath_pwm #(
        .PWM_BITS   (PWM_BITS),
        .STEP_DIV   (STEP_DIV),
        .HOLD_STEPS (HOLD_STEPS)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (en),
        .led_pwm (led_pwm),
        .duty    (duty),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Clocks since the last reset edge; a step edge lands where tcnt becomes
    // a multiple of STEP_CYC.
    always @(posedge sys_clk) tcnt <= sys_rst ? 0 : tcnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s @tcnt=%0d: observed %0d expected %0d", tag, tcnt, got, want);
        end
    endtask

    task automatic push(input int d, input bit b);
        exp_t e;
        e.duty = PWM_BITS'(d);
        e.busy = b;
        sbq.push_back(e);
    endtask

    task automatic push_ramp(input int from, input int to, input bit b);
        if (from <= to) begin
            for (int i = from; i <= to; i++) push(i, b);
        end else begin
            for (int i = from; i >= to; i--) push(i, b);
        end
    endtask

    task automatic wait_tcnt(input int target);
        int n;
        n = 0;
        while (tcnt != target && n < 5000) begin
            @(negedge sys_clk);
            n++;
        end
        if (tcnt != target) begin
            checks++;
            errors++;
            $error("FAIL wait_tcnt: observed %0d expected %0d", tcnt, target);
        end
    endtask

    // Monitor: pops expectations at step boundaries, checks duty/busy every
    // cycle and the high count of every complete PWM period.
    initial begin
        exp_t                e;
        logic [PWM_BITS-1:0] exp_duty;
        logic                exp_busy;
        int                  hi_cnt;
        int                  per_duty;
        bit                  per_valid;
        exp_duty  = '0;
        exp_busy  = 1'b0;
        hi_cnt    = 0;
        per_duty  = 0;
        per_valid = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst || !track) begin
                per_valid = 1'b0;
                hi_cnt    = 0;
                if (sys_rst) begin
                    exp_duty = '0;
                    exp_busy = 1'b0;
                end
            end else begin
                hi_cnt += (led_pwm === 1'b1) ? 1 : 0;
                if (tcnt > 0 && tcnt % STEP_CYC == 0) begin
                    checks++;
                    assert (sbq.size() > 0) else begin
                        errors++;
                        $error("FAIL sb_underflow @tcnt=%0d: observed %0d expected %0d", tcnt, 0, 1);
                    end
                    if (sbq.size() > 0) begin
                        e        = sbq.pop_front();
                        exp_duty = e.duty;
                        exp_busy = e.busy;
                    end
                end
                if (tcnt > 0 && tcnt % PERIOD == 0) begin
                    if (per_valid) chk("period_high", hi_cnt, per_duty);
                    per_duty  = int'(exp_duty);
                    per_valid = 1'b1;
                    hi_cnt    = 0;
                end
                chk("duty", duty, exp_duty);
                chk("busy", busy, exp_busy);
            end
        end
    end

    initial begin
        // Reset held with en high: everything stays at zero.
        repeat (5) begin
            @(negedge sys_clk);
            chk("rst_led", led_pwm, 0);
            chk("rst_duty", duty, 0);
            chk("rst_busy", busy, 0);
        end
        sys_rst = 1'b0;

        // Full breath, then continue rising to duty 6.
        push(0, 1'b1);
        push_ramp(1, 15, 1'b1);
        push_ramp(15, 15, 1'b1);
        push_ramp(15, 15, 1'b1);
        push_ramp(15, 15, 1'b1);
        push_ramp(14, 0, 1'b1);
        push_ramp(0, 0, 1'b1);
        push_ramp(0, 0, 1'b1);
        push_ramp(0, 0, 1'b1);
        push_ramp(1, 6, 1'b1);
        track = 1'b1;

        // Abort while rising at duty 6.
        wait_tcnt(43 * STEP_CYC + 1);
        en = 1'b0;
        push(6, 1'b1);
        push_ramp(5, 1, 1'b1);
        push(0, 1'b0);
        push(0, 1'b0);

        // Short en pulse between steps: no effect.
        wait_tcnt(51 * STEP_CYC + 5);
        en = 1'b1;
        push(0, 1'b0);
        push(0, 1'b0);
        wait_tcnt(51 * STEP_CYC + 8);
        en = 1'b0;

        // Restart and run into FALL down to duty 9.
        wait_tcnt(53 * STEP_CYC + 1);
        en = 1'b1;
        push(0, 1'b1);
        push_ramp(1, 15, 1'b1);
        push_ramp(15, 15, 1'b1);
        push_ramp(15, 15, 1'b1);
        push_ramp(15, 15, 1'b1);
        push_ramp(14, 9, 1'b1);

        // Reset mid-ramp.
        wait_tcnt(78 * STEP_CYC + 1);
        chk("pre_rst_led", led_pwm, 1);
        track   = 1'b0;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("midrst_led", led_pwm, 0);
        chk("midrst_duty", duty, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        push(0, 1'b1);
        push(1, 1'b1);
        push(2, 1'b1);
        track = 1'b1;
        wait_tcnt(3 * STEP_CYC + 1);
        track = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
